// File: rtl/load_mem_unit.sv
// rtl/load_mem_unit.sv - load-path BRAM responder with sign/zero extension, result queue and CDB broadcast
module load_mem_result_q #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk_in,
  input  logic         clr_in,
  input  logic         push_in,
  input  logic [W-1:0] push_data_in,
  input  logic         pop_in,
  output logic         valid_out,
  output logic [W-1:0] head_out
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop_in && (count != '0);
  assign do_push   = push_in && ((count != CW'(DEPTH)) || do_pop);
  assign valid_out = (count != '0);
  assign head_out  = valid_out ? entries[rd_ptr] : '0;

  always_ff @(posedge clk_in) begin
    if (clr_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !clr_in) entries[wr_ptr] <= push_data_in;
  end
endmodule

module load_mem_unit #(
  parameter int MEM_LATENCY  = 2,
  parameter int MEM_WORDS    = 4096,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         lb_valid_in,
  input  logic [31:0]                  lb_addr_in,
  input  logic [2:0]                   lb_rob_ix_in,
  input  logic [2:0]                   lb_funct3_in,
  output logic                         lb_read_out,
  input  logic                         flush_in,
  output logic                         mem_rd_en_out,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_out,
  input  logic [31:0]                  mem_rdata_in,
  output logic                         cdb_valid_out,
  output logic [31:0]                  cdb_value_out,
  output logic [2:0]                   cdb_rob_ix_out,
  output logic                         cdb_fault_out,
  input  logic                         cdb_grant_in
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RESULT_DEPTH + 1);
  localparam int LAST = MEM_LATENCY - 1;

  logic          kill;
  logic          pop;
  logic          accept;
  logic [CW-1:0] credits;

  logic          tag_valid [MEM_LATENCY];
  logic [2:0]    tag_rob   [MEM_LATENCY];
  logic [2:0]    tag_f3    [MEM_LATENCY];
  logic [1:0]    tag_off   [MEM_LATENCY];

  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ext_value;
  logic          ext_fault;
  logic          push;
  logic [35:0]   head;

  logic          unused_addr;
  assign unused_addr = ^lb_addr_in[31:AW+2];

  assign kill = rst_in || flush_in;
  assign pop  = cdb_valid_out && cdb_grant_in;

  // A pop retires its credit in the same cycle, so a full unit can accept on the grant cycle.
  assign accept      = lb_valid_in && !kill && ((credits - CW'(pop)) < CW'(RESULT_DEPTH));
  assign lb_read_out = accept;

  assign mem_rd_en_out = accept;
  assign mem_addr_out  = accept ? lb_addr_in[AW+1:2] : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      credits <= '0;
    end else begin
      credits <= credits + CW'(accept) - CW'(pop);
    end
  end

  // Tags never stall: credits guarantee the queue has room when the data lands.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      for (int i = 0; i < MEM_LATENCY; i++) tag_valid[i] <= 1'b0;
    end else begin
      tag_valid[0] <= accept;
      for (int i = 1; i < MEM_LATENCY; i++) tag_valid[i] <= tag_valid[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    tag_rob[0] <= lb_rob_ix_in;
    tag_f3[0]  <= lb_funct3_in;
    tag_off[0] <= lb_addr_in[1:0];
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_rob[i] <= tag_rob[i-1];
      tag_f3[i]  <= tag_f3[i-1];
      tag_off[i] <= tag_off[i-1];
    end
  end

  always_comb begin
    sel_byte  = mem_rdata_in[7:0];
    sel_half  = tag_off[LAST][1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    ext_value = '0;
    ext_fault = 1'b0;
    case (tag_off[LAST])
      2'd1:    sel_byte = mem_rdata_in[15:8];
      2'd2:    sel_byte = mem_rdata_in[23:16];
      2'd3:    sel_byte = mem_rdata_in[31:24];
      default: sel_byte = mem_rdata_in[7:0];
    endcase
    case (tag_f3[LAST])
      3'b000: ext_value = {{24{sel_byte[7]}}, sel_byte};
      3'b100: ext_value = {24'd0, sel_byte};
      3'b001: begin
        ext_value = {{16{sel_half[15]}}, sel_half};
        ext_fault = tag_off[LAST][0];
      end
      3'b101: begin
        ext_value = {16'd0, sel_half};
        ext_fault = tag_off[LAST][0];
      end
      3'b010: begin
        ext_value = mem_rdata_in;
        ext_fault = (tag_off[LAST] != 2'd0);
      end
      default: ext_fault = 1'b1;
    endcase
    if (ext_fault) ext_value = '0;
  end

  // The queue entry doubles as the extend-stage register.
  assign push = tag_valid[LAST] && !kill;

  load_mem_result_q #(
    .DEPTH (RESULT_DEPTH),
    .W     (36)
  ) u_result_q (
    .clk_in       (clk_in),
    .clr_in       (kill),
    .push_in      (push),
    .push_data_in ({ext_value, tag_rob[LAST], ext_fault}),
    .pop_in       (pop && !kill),
    .valid_out    (cdb_valid_out),
    .head_out     (head)
  );

  assign cdb_value_out  = head[35:4];
  assign cdb_rob_ix_out = head[3:1];
  assign cdb_fault_out  = head[0];
endmodule

// File: tb/tb_load_mem_unit.sv
// tb/tb_load_mem_unit.sv - directed and random-soak bench for load_mem_unit
module tb_load_mem_unit;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        lb_valid_in;
  logic [31:0] lb_addr_in;
  logic [2:0]  lb_rob_ix_in;
  logic [2:0]  lb_funct3_in;
  logic        lb_read_out;
  logic        flush_in;
  logic        mem_rd_en_out;
  logic [11:0] mem_addr_out;
  logic [31:0] mem_rdata_in;
  logic        cdb_valid_out;
  logic [31:0] cdb_value_out;
  logic [2:0]  cdb_rob_ix_out;
  logic        cdb_fault_out;
  logic        cdb_grant_in;

  always #5 clk_in = ~clk_in;

  load_mem_unit dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .lb_valid_in    (lb_valid_in),
    .lb_addr_in     (lb_addr_in),
    .lb_rob_ix_in   (lb_rob_ix_in),
    .lb_funct3_in   (lb_funct3_in),
    .lb_read_out    (lb_read_out),
    .flush_in       (flush_in),
    .mem_rd_en_out  (mem_rd_en_out),
    .mem_addr_out   (mem_addr_out),
    .mem_rdata_in   (mem_rdata_in),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_rob_ix_out (cdb_rob_ix_out),
    .cdb_fault_out  (cdb_fault_out),
    .cdb_grant_in   (cdb_grant_in)
  );

  // Two-cycle BRAM model
  logic [31:0] mem [4096];
  logic [31:0] d1 = 32'h0;
  logic [31:0] d2 = 32'h0;
  always @(posedge clk_in) begin
    d1 <= mem_rd_en_out ? mem[mem_addr_out] : 32'h0;
    d2 <= d1;
  end
  assign mem_rdata_in = d2;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] v;
    logic [2:0]  rob;
    logic        f;
    int          t;
  } res_t;
  res_t obs_q[$];
  res_t exp_q[$];
  res_t mon_r;

  always @(negedge clk_in) begin
    if (cdb_valid_out && cdb_grant_in && !flush_in && !rst_in) begin
      mon_r.v   = cdb_value_out;
      mon_r.rob = cdb_rob_ix_out;
      mon_r.f   = cdb_fault_out;
      mon_r.t   = cyc;
      obs_q.push_back(mon_r);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic acc;
  int   acc_cyc;

  task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] rob,
                       input logic [2:0] f3, input logic g, input logic fl);
    @(posedge clk_in);
    #1;
    lb_valid_in  = v;
    lb_addr_in   = a;
    lb_rob_ix_in = rob;
    lb_funct3_in = f3;
    cdb_grant_in = g;
    flush_in     = fl;
    @(negedge clk_in);
    acc = lb_read_out;
    if (acc) acc_cyc = cyc;
  endtask

  task automatic idle(input int n, input logic g);
    repeat (n) drive(1'b0, 32'h0, 3'd0, 3'd0, g, 1'b0);
  endtask

  function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'b000:  return {1'b0, {24{sh[7]}}, sh[7:0]};
      3'b100:  return {1'b0, 24'd0, sh[7:0]};
      3'b001:  return a[0] ? {1'b1, 32'd0} : {1'b0, {16{sh[15]}}, sh[15:0]};
      3'b101:  return a[0] ? {1'b1, 32'd0} : {1'b0, 16'd0, sh[15:0]};
      3'b010:  return (a == 2'd0) ? {1'b0, w} : {1'b1, 32'd0};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  logic [31:0] t1_addr [6] = '{32'd4, 32'd7, 32'd6, 32'd4, 32'd4, 32'h4004};
  logic [2:0]  t1_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
  logic [31:0] t1_exp  [6] = '{32'hFFFFFFF3, 32'h00000080, 32'hFFFF8081,
                               32'h0000F2F3, 32'h8081F2F3, 32'hFFFFFFF3};
  logic [31:0] t2_addr [3] = '{32'd5, 32'd3, 32'd4};
  logic [2:0]  t2_f3   [3] = '{3'b010, 3'b001, 3'b011};

  int          nacc;
  int          first_t;
  int          outst;
  int          maxo;
  logic [2:0]  rob_ctr;
  logic [32:0] r;
  res_t        e;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[1] = 32'h8081F2F3;
    rst_in = 1'b1; lb_valid_in = 1'b0; lb_addr_in = 32'h0; lb_rob_ix_in = 3'd0;
    lb_funct3_in = 3'd0; flush_in = 1'b0; cdb_grant_in = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1 lb_valid_in = 1'b1; lb_addr_in = 32'd4;
    @(negedge clk_in);
    check("rst_read", lb_read_out, 0);
    check("rst_rd_en", mem_rd_en_out, 0);
    check("rst_addr", mem_addr_out, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0; lb_valid_in = 1'b0;
    @(negedge clk_in);
    check("rst_cdb_valid", cdb_valid_out, 0);
    check("rst_cdb_value", cdb_value_out, 0);
    check("rst_cdb_rob", cdb_rob_ix_out, 0);
    check("rst_cdb_fault", cdb_fault_out, 0);

    // Back-to-back extension cases, grant high
    obs_q.delete(); nacc = 0; first_t = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t1_addr[i], 3'(i), t1_f3[i], 1'b1, 1'b0);
      if (acc) nacc++;
      if (i == 0) first_t = acc_cyc;
    end
    idle(8, 1'b1);
    check("t1_accepts", nacc, 6);
    check("t1_count", obs_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("t1_val%0d", i), obs_q[i].v, t1_exp[i]);
        check($sformatf("t1_rob%0d", i), obs_q[i].rob, i);
        check($sformatf("t1_fault%0d", i), obs_q[i].f, 0);
      end
    end
    if (obs_q.size() > 0) check("t1_latency", obs_q[0].t - first_t, 3);

    // Misaligned and illegal funct3
    obs_q.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, t2_addr[i], 3'(i + 2), t2_f3[i], 1'b1, 1'b0);
    idle(8, 1'b1);
    check("t2_count", obs_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("t2_val%0d", i), obs_q[i].v, 0);
        check($sformatf("t2_rob%0d", i), obs_q[i].rob, i + 2);
        check($sformatf("t2_fault%0d", i), obs_q[i].f, 1);
      end
    end

    // Backpressure
    obs_q.delete(); nacc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'd4, 3'(nacc), 3'b010, 1'b0, 1'b0);
      if (acc) nacc++;
    end
    check("bp_accepts", nacc, 4);
    check("bp_read_low", lb_read_out, 0);
    check("bp_valid", cdb_valid_out, 1);
    check("bp_head_rob0", cdb_rob_ix_out, 0);
    drive(1'b1, 32'd4, 3'd4, 3'b010, 1'b1, 1'b0);
    check("bp_grant_read", acc, 1);
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("bp_head_rob1", cdb_rob_ix_out, 1);
    check("bp_head_valid", cdb_valid_out, 1);
    idle(12, 1'b1);
    check("bp_drained", obs_q.size(), 5);

    // Flush
    obs_q.delete(); nacc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd4, 3'(i), 3'b010, 1'b1, 1'b0);
      if (acc) nacc++;
    end
    check("fl_accepts", nacc, 3);
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    drive(1'b1, 32'd4, 3'd5, 3'b010, 1'b1, 1'b0);
    check("fl_new_accept", acc, 1);
    first_t = acc_cyc;
    idle(8, 1'b1);
    check("fl_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("fl_rob", obs_q[0].rob, 5);
      check("fl_val", obs_q[0].v, 32'h8081F2F3);
      check("fl_latency", obs_q[0].t - first_t, 3);
    end
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd4, 3'(i), 3'b010, 1'b0, 1'b0);
      if (acc) nacc++;
    end
    check("fl_credits", nacc, 4);

    // Reset with a full queue and grant low
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    check("mr_read", lb_read_out, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0; lb_valid_in = 1'b0;
    @(negedge clk_in);
    check("mr_cdb_valid", cdb_valid_out, 0);
    check("mr_cdb_value", cdb_value_out, 0);
    check("mr_cdb_rob", cdb_rob_ix_out, 0);
    check("mr_cdb_fault", cdb_fault_out, 0);
    check("mr_rd_en", mem_rd_en_out, 0);
    check("mr_addr", mem_addr_out, 0);
    check("mr_read_idle", lb_read_out, 0);
    obs_q.delete();
    drive(1'b1, 32'd4, 3'd6, 3'b010, 1'b1, 1'b0);
    idle(8, 1'b1);
    check("mr_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("mr_val", obs_q[0].v, 32'h8081F2F3);
      check("mr_rob", obs_q[0].rob, 6);
    end

    // Random soak against the reference model
    obs_q.delete(); exp_q.delete(); maxo = 0; rob_ctr = 3'd0;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, rob_ctr, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6), 1'b0);
      #1;
      if (acc) begin
        r     = ref_load(mem[lb_addr_in[13:2]], lb_funct3_in, lb_addr_in[1:0]);
        e.v   = r[31:0];
        e.f   = r[32];
        e.rob = rob_ctr;
        e.t   = 0;
        exp_q.push_back(e);
        rob_ctr = rob_ctr + 3'd1;
      end
      outst = exp_q.size() - obs_q.size();
      if (outst > maxo) maxo = outst;
    end
    idle(20, 1'b1);
    check("soak_count", obs_q.size(), exp_q.size());
    check("soak_credit_max", (maxo <= 4), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("soak_val%0d", i), obs_q[i].v, exp_q[i].v);
        check($sformatf("soak_rob%0d", i), obs_q[i].rob, exp_q[i].rob);
        check($sformatf("soak_fault%0d", i), obs_q[i].f, exp_q[i].f);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
